// File: rtl/udt_socket_pkg.sv
// Shared UDT socket definitions: state codes written to the socket state register
// and the encoding of the state-write arbiter FSM.
package udt_socket_pkg;

  localparam logic [31:0] UDT_ST_CONNECTED = 32'h0000_0010;
  localparam logic [31:0] UDT_ST_CLOSED    = 32'h0000_1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_ACK  = 2'd2
  } udt_arb_state_e;

endpackage

// File: rtl/udt_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or after
// the pointer, wrapping from N_REQ-1 back to 0. Wrap is at N_REQ, not 2^IDX_W.
module udt_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_req_o,
  output logic [IDX_W-1:0] grant_o
);

  logic             hit_hi;
  logic             hit_lo;
  logic [IDX_W-1:0] g_hi;
  logic [IDX_W-1:0] g_lo;

  // Lowest request at/above the pointer wins; otherwise wrap to the lowest request overall.
  always_comb begin
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    g_hi   = '0;
    g_lo   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_i[i] && !hit_lo) begin
        hit_lo = 1'b1;
        g_lo   = IDX_W'(i);
      end
      if (req_i[i] && (i >= 32'(ptr_i)) && !hit_hi) begin
        hit_hi = 1'b1;
        g_hi   = IDX_W'(i);
      end
    end
    any_req_o = hit_lo;
    grant_o   = hit_hi ? g_hi : g_lo;
  end

endmodule

// File: rtl/udt_state_arbiter.sv
// Round-robin arbiter sharing one UDT state-register write channel among N_REQ
// socket controllers. One write in flight; all handshake outputs registered.
// Optional SEND watchdog enabled by defining UDT_STATE_ARB_TIMEOUT_EN.
module udt_state_arbiter
  import udt_socket_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                    core_clk,
  input  logic                    core_rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_state,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_state,
  output logic [IDX_W-1:0]        out_src,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    err_timeout
);

  udt_arb_state_e    state_q, state_d;
  logic [N_REQ-1:0]  ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  src_q, src_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  logic              any_req;
  logic [IDX_W-1:0]  pick_idx;
  logic [DATA_W-1:0] pick_word;
  logic [N_REQ-1:0]  ack_vec;

`ifdef UDT_STATE_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_q, err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

  udt_rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .any_req_o(any_req),
    .grant_o  (pick_idx)
  );

  // Select the winning requester's word and build the one-hot ack for the owner.
  always_comb begin
    pick_word = '0;
    ack_vec   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_word = req_state[i*DATA_W +: DATA_W];
      ack_vec[i] = (src_q == IDX_W'(i));
    end
  end

  // Next-state and registered-output logic for the IDLE/SEND/ACK handshake.
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
`ifdef UDT_STATE_ARB_TIMEOUT_EN
    wdog_d  = wdog_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        ready_d = '0;
        if (any_req) begin
          data_d  = pick_word;
          src_d   = pick_idx;
          valid_d = 1'b1;
          state_d = S_SEND;
`ifdef UDT_STATE_ARB_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end
      end
      S_SEND: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          ready_d = ack_vec;
          state_d = S_ACK;
        end
`ifdef UDT_STATE_ARB_TIMEOUT_EN
        // Expiry releases the socket exactly like a normal completion, plus an error pulse.
        else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
          valid_d = 1'b0;
          ready_d = ack_vec;
          err_d   = 1'b1;
          state_d = S_ACK;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      S_ACK: begin
        ready_d = '0;
        ptr_d   = (src_q == IDX_W'(N_REQ - 1)) ? '0 : src_q + 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = '0;
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; async reset abandons any transfer without an ack.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q <= S_IDLE;
      ready_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef UDT_STATE_ARB_TIMEOUT_EN
  // SEND watchdog counter and its error pulse.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign req_ready = ready_q;
  assign out_valid = valid_q;
  assign out_state = data_q;
  assign out_src   = src_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_udt_state_arbiter.sv
// Bench for udt_state_arbiter: per-socket request queues, transaction-level reference
// model (grant = first pending socket at/after the model pointer), directed steps
// followed by randomized traffic, plus a 3-requester instance for non-power-of-2 wrap.
module tb_udt_state_arbiter;
  import udt_socket_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 2;
  localparam int unsigned TO = 8;
  localparam int unsigned QD = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_ready;
  logic [N*DW-1:0] req_state;
  logic          out_valid, out_ready, busy, err_timeout;
  logic [DW-1:0] out_state;
  logic [IW-1:0] out_src;

  logic [2:0]    v3, r3;
  logic [3*DW-1:0] s3;
  logic          ov3, or3, b3, e3;
  logic [DW-1:0] os3;
  logic [IW-1:0] src3;

  always #5 clk = ~clk;

  udt_state_arbiter #(.N_REQ(N), .DATA_W(DW), .IDX_W(IW), .TIMEOUT_CYC(TO)) u_dut (
    .core_clk(clk), .core_rst_n(rst_n), .req_valid(req_valid), .req_state(req_state),
    .req_ready(req_ready), .out_valid(out_valid), .out_state(out_state), .out_src(out_src),
    .out_ready(out_ready), .busy(busy), .err_timeout(err_timeout));

  udt_state_arbiter #(.N_REQ(3), .DATA_W(DW), .IDX_W(IW), .TIMEOUT_CYC(TO)) u_dut3 (
    .core_clk(clk), .core_rst_n(rst_n), .req_valid(v3), .req_state(s3),
    .req_ready(r3), .out_valid(ov3), .out_state(os3), .out_src(src3),
    .out_ready(or3), .busy(b3), .err_timeout(e3));

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  logic [DW-1:0] qbuf [N][QD];
  int unsigned   hd [N];
  int unsigned   tl [N];
  bit            withdraw [N];
  int unsigned   ptr_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (tl[i] != hd[i]) && !withdraw[i];
      req_state[i*DW +: DW] = (tl[i] != hd[i]) ? qbuf[i][hd[i] % QD] : '0;
    end
  endfunction

  function automatic void push(input int unsigned s, input logic [DW-1:0] w);
    qbuf[s][tl[s] % QD] = w;
    tl[s]++;
    drive();
  endfunction

  function automatic void pop(input int unsigned s);
    hd[s]++;
    drive();
  endfunction

  // Reference grant: first socket with a pending word at or after the pointer.
  function automatic int unsigned model_pick();
    for (int unsigned k = 0; k < N; k++) begin
      if (tl[(ptr_m + k) % N] != hd[(ptr_m + k) % N]) return (ptr_m + k) % N;
    end
    return N;
  endfunction

  // One complete write, starting in IDLE with at least one pending socket.
  task automatic run_xfer(input int unsigned stall, input bit drop, input bit inject,
                          output int unsigned g);
    int unsigned   gm;
    logic [DW-1:0] wexp;
    gm   = model_pick();
    wexp = qbuf[gm][hd[gm] % QD];
    out_ready = 1'b0;
    tick();
    chk("grant_valid", out_valid, 1);
    chk("grant_src", out_src, gm);
    chk("grant_state", out_state, wexp);
    chk("grant_busy", busy, 1);
    chk("grant_noack", req_ready, 0);
    g = out_src;
    if (drop) begin
      withdraw[gm] = 1'b1;
      drive();
    end
    if (inject) push($urandom_range(0, N - 1), $urandom);
    for (int unsigned c = 0; c < stall; c++) begin
      tick();
`ifdef UDT_STATE_ARB_TIMEOUT_EN
      if (c == TO - 1) begin
        chk("to_valid", out_valid, 0);
        chk("to_err", err_timeout, 1);
        chk("to_ack", req_ready, 64'(1) << gm);
        withdraw[gm] = 1'b0;
        pop(gm);
        tick();
        chk("to_err_clr", err_timeout, 0);
        chk("to_ack_clr", req_ready, 0);
        chk("to_idle", busy, 0);
        ptr_m = (gm + 1) % N;
        return;
      end
`endif
      chk("stall_valid", out_valid, 1);
      chk("stall_state", out_state, wexp);
      chk("stall_src", out_src, gm);
      chk("stall_noack", req_ready, 0);
      chk("stall_err", err_timeout, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("ack_valid", out_valid, 0);
    chk("ack_vec", req_ready, 64'(1) << gm);
    chk("ack_busy", busy, 1);
    chk("ack_err", err_timeout, 0);
    withdraw[gm] = 1'b0;
    pop(gm);
    out_ready = 1'b0;
    tick();
    chk("idle_ack", req_ready, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    ptr_m = (gm + 1) % N;
  endtask

  initial begin
    int unsigned g;
    int unsigned start;
    int unsigned nw;
    int unsigned exp3;
    int unsigned grants;
    logic        prev;

    for (int i = 0; i < N; i++) begin
      hd[i] = 0;
      tl[i] = 0;
      withdraw[i] = 1'b0;
    end
    ptr_m = 0;
    rst_n = 1'b0;
    out_ready = 1'b0;
    req_valid = '0;
    req_state = '0;
    v3 = '0;
    s3 = '0;
    or3 = 1'b0;
    drive();
    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_state", out_state, 0);
    chk("rst_src", out_src, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_nobusy", busy, 0);

    // Single request on socket 2.
    push(2, UDT_ST_CONNECTED);
    run_xfer(0, 0, 0, g);
    chk("t1_src", g, 2);

    // Writer stalls five cycles.
    push(1, UDT_ST_CLOSED);
    run_xfer(5, 0, 0, g);
    chk("t3_src", g, 1);

    // All sockets held valid: strict rotation.
    start = ptr_m;
    for (int unsigned s = 0; s < N; s++) begin
      push(s, 32'hA000 + s);
      push(s, 32'hB000 + s);
    end
    for (int unsigned k = 0; k < 2 * N; k++) begin
      run_xfer(0, 0, 0, g);
      chk("rot_src", g, (start + k) % N);
    end

    // Reset during SEND: no ack, pointer back to 0.
    push(0, 32'h0000_0C00);
    run_xfer(0, 0, 0, g);
    chk("pre_rst_ptr", ptr_m, 1);
    push(0, 32'h0000_0C01);
    push(2, 32'h0000_0C02);
    tick();
    chk("mid_src", out_src, 2);
    chk("mid_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_state", out_state, 0);
    chk("arst_src", out_src, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", req_ready, 0);
    tick();
    chk("arst_noack", req_ready, 0);
    rst_n = 1'b1;
    ptr_m = 0;
    run_xfer(0, 0, 0, g);
    chk("post_rst_src0", g, 0);
    run_xfer(0, 0, 0, g);
    chk("post_rst_src2", g, 2);

    // Writer never ready: watchdog expiry when enabled, indefinite wait otherwise.
    push(3, UDT_ST_CLOSED);
    run_xfer(12, 0, 0, g);
    chk("t5_src", g, 3);

    // Two sockets each connect then close.
    push(1, UDT_ST_CONNECTED);
    push(3, UDT_ST_CONNECTED);
    push(1, UDT_ST_CLOSED);
    push(3, UDT_ST_CLOSED);
    nw = 0;
    while (model_pick() != N && nw < 10) begin
      run_xfer($urandom_range(0, 2), 0, 0, g);
      nw++;
    end
    chk("t6_writes", nw, 4);

    // Randomized traffic with withdrawals and requests arriving mid-transfer.
    for (int unsigned it = 0; it < 40; it++) begin
      for (int unsigned p = $urandom_range(0, 2); p > 0; p--) begin
        push($urandom_range(0, N - 1),
             ($urandom_range(0, 2) == 0) ? UDT_ST_CONNECTED :
             ($urandom_range(0, 1) == 0) ? UDT_ST_CLOSED : $urandom);
      end
      if (model_pick() == N) begin
        tick();
        chk("rnd_idle_busy", busy, 0);
        chk("rnd_idle_valid", out_valid, 0);
      end else begin
        run_xfer($urandom_range(0, 4), ($urandom_range(0, 3) == 0), $urandom_range(0, 1), g);
      end
    end
    while (model_pick() != N) run_xfer(0, 0, 0, g);

    // Three requesters: wrap at 3, one grant every 3 cycles.
    for (int i = 0; i < 3; i++) s3[i*DW +: DW] = 32'hC0 + i;
    v3 = 3'b111;
    or3 = 1'b1;
    exp3 = 0;
    grants = 0;
    prev = 1'b0;
    for (int unsigned cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (ov3 && !prev) begin
        chk("n3_src", src3, exp3);
        chk("n3_state", os3, 32'hC0 + exp3);
        exp3 = (exp3 + 1) % 3;
        grants++;
      end
      prev = ov3;
    end
    chk("n3_grants", grants, 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
